fine_delay_apod: RTL and testbench

//  Per-channel DBF stage directly downstream of the coarse-delay LUT stage: accepts coarse-delayed

---
 rtl/fine_delay_apod_if.sv | 33 +++
 rtl/fine_delay_apod.sv | 162 ++++++++++++++++
 tb/tb_fine_delay_apod.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fine_delay_apod_if.sv
// Sample, LUT-load and output bundle for the fine-delay / apodization channel stage.
// Signal direction prefixes are from the point of view of fine_delay_apod.
interface fine_delay_apod_if #(
  parameter int INPUT_WD = 14,
  parameter int APO_WD   = 16,
  parameter int ADDR_WD  = 12,
  parameter int PH_WD    = 2,
  parameter int OUT_WD   = 32
) ();
  logic                       i_tx_en;
  logic                       i_start;
  logic [ADDR_WD-1:0]         i_lut_addr;
  logic                       i_lut_we;
  logic [PH_WD-1:0]           i_lut_wdata;
  logic signed [INPUT_WD-1:0] i_fine_din;
  logic                       i_fine_din_valid;
  logic signed [APO_WD-1:0]   i_apo_din;
  logic signed [OUT_WD-1:0]   o_dbf_dout;
  logic                       o_dbf_dout_valid;
  logic                       o_lut_done;

  modport slave (
    input  i_tx_en, i_start, i_lut_addr, i_lut_we, i_lut_wdata,
           i_fine_din, i_fine_din_valid, i_apo_din,
    output o_dbf_dout, o_dbf_dout_valid, o_lut_done
  );

  modport master (
    output i_tx_en, i_start, i_lut_addr, i_lut_we, i_lut_wdata,
           i_fine_din, i_fine_din_valid, i_apo_din,
    input  o_dbf_dout, o_dbf_dout_valid, o_lut_done
  );
endinterface

// File: rtl/fine_delay_apod.sv
// Fine (fractional) delay by linear interpolation, then apodization weighting, for one DBF channel.
// Optional macro FD_ROUND_EN: round-half-up the interpolation step instead of floor.
//
// state | meaning
// IDLE  | line inactive; fine LUT writable
// RUN   | receive line active; one LUT entry consumed per accepted sample
// DONE  | all LUT entries consumed; waiting for start to go low to re-arm
module fine_delay_apod #(
  parameter int INPUT_WD = 14,
  parameter int APO_WD   = 16,
  parameter int ADDR_WD  = 12,
  parameter int PH_WD    = 2,
  parameter int OUT_WD   = 32
) (
  input  logic              clk,
  input  logic              rst,
  fine_delay_apod_if.slave  bus
);

  localparam int DW = INPUT_WD + 1;
  localparam int PW = DW + PH_WD + 1;
  localparam int MW = DW + APO_WD;
  localparam logic [ADDR_WD-1:0] IDX_LAST = {ADDR_WD{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   w_arm;
  logic   w_flush;
  logic   w_accept;
  logic   w_take;

  logic [PH_WD-1:0]           r_lut [2**ADDR_WD];
  logic [ADDR_WD-1:0]         r_idx;
  logic signed [INPUT_WD-1:0] r_x_prev;

  logic                       r_s1_v;
  logic signed [INPUT_WD-1:0] r_s1_x;
  logic signed [INPUT_WD-1:0] r_s1_xp;
  logic [PH_WD-1:0]           r_s1_ph;

  logic                       r_s2_v;
  logic signed [DW-1:0]       r_s2_y;

  logic                       r_out_v;
  logic signed [OUT_WD-1:0]   r_dout;

  logic signed [DW-1:0]       w_d;
  logic signed [PW-1:0]       w_prod;
  logic signed [PW-1:0]       w_sum;
  logic signed [PW-1:0]       w_sh;
  logic signed [DW-1:0]       w_y;
  logic signed [MW-1:0]       w_m;

  assign w_accept = bus.i_fine_din_valid && !bus.i_tx_en && (r_state == ST_RUN);
  // A strobe in the cycle start falls is swallowed by the flush.
  assign w_take   = w_accept && bus.i_start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_arm       = 1'b0;
    w_flush     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.i_start) begin
          w_state_nxt = ST_RUN;
          w_arm       = 1'b1;
        end
      end
      ST_RUN: begin
        if (!bus.i_start) begin
          w_state_nxt = ST_IDLE;
          w_flush     = 1'b1;
        end else if (w_accept && (r_idx == IDX_LAST)) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (!bus.i_start) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (bus.i_lut_we && (r_state == ST_IDLE))
      r_lut[bus.i_lut_addr] <= bus.i_lut_wdata;
  end

  // S1: capture sample, its predecessor and the phase for this sample index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx    <= '0;
      r_x_prev <= '0;
      r_s1_v   <= 1'b0;
      r_s1_x   <= '0;
      r_s1_xp  <= '0;
      r_s1_ph  <= '0;
    end else begin
      r_s1_v <= w_take;
      if (w_arm) begin
        r_idx    <= '0;
        r_x_prev <= '0;
      end else if (w_take) begin
        r_s1_x   <= bus.i_fine_din;
        r_s1_xp  <= r_x_prev;
        r_s1_ph  <= r_lut[r_idx];
        r_x_prev <= bus.i_fine_din;
        r_idx    <= r_idx + 1'b1;
      end
    end
  end

  assign w_d    = DW'(r_s1_xp) - DW'(r_s1_x);
  assign w_prod = PW'(w_d) * $signed({{(PW-PH_WD){1'b0}}, r_s1_ph});
`ifdef FD_ROUND_EN
  localparam logic signed [PW-1:0] RND = PW'(2 ** (PH_WD - 1));
  assign w_sum = w_prod + RND;
`else
  assign w_sum = w_prod;
`endif
  assign w_sh = w_sum >>> PH_WD;
  // Result lies between x and x_prev, so the truncation to DW bits is lossless.
  assign w_y  = DW'(r_s1_x) + $signed(w_sh[DW-1:0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_v <= 1'b0;
      r_s2_y <= '0;
    end else begin
      r_s2_v <= r_s1_v && !w_flush;
      if (r_s1_v) r_s2_y <= w_y;
    end
  end

  assign w_m = MW'(r_s2_y) * MW'(bus.i_apo_din);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_v <= 1'b0;
      r_dout  <= '0;
    end else begin
      r_out_v <= r_s2_v && !w_flush;
      if (r_s2_v && !w_flush) r_dout <= OUT_WD'(w_m);
    end
  end

  assign bus.o_dbf_dout       = r_dout;
  assign bus.o_dbf_dout_valid = r_out_v;
  assign bus.o_lut_done       = (r_state == ST_DONE);

endmodule

// File: tb/tb_fine_delay_apod.sv
// Self-checking bench for fine_delay_apod: directed cases plus randomized lines against an arithmetic model.
module tb_fine_delay_apod;
  localparam int IW  = 14;
  localparam int AW  = 16;
  localparam int ADW = 2;
  localparam int PHW = 2;
  localparam int OW  = 32;
  localparam int DEPTH = 1 << ADW;
  // Accept edge -> output valid seen in the cycle two edges later (3rd period after the input).
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   vecs = 0;
  int   errs = 0;

  longint out_q[$];
  int     out_c[$];
  int     lut_m[DEPTH];

  fine_delay_apod_if #(.INPUT_WD(IW), .APO_WD(AW), .ADDR_WD(ADW), .PH_WD(PHW), .OUT_WD(OW)) bus ();

  fine_delay_apod #(.INPUT_WD(IW), .APO_WD(AW), .ADDR_WD(ADW), .PH_WD(PHW), .OUT_WD(OW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.o_dbf_dout_valid === 1'b1) begin
      out_q.push_back(longint'(bus.o_dbf_dout));
      out_c.push_back(cyc);
    end
  end

  function automatic longint fdiv(longint n, longint d);
    if (n >= 0) return n / d;
    return -((-n + d - 1) / d);
  endfunction

  // Linear interpolation toward the previous sample by ph/2**PHW, then weight.
  function automatic longint ref_out(longint x, longint xp, int ph, longint apo);
    longint num;
    num = (xp - x) * ph;
`ifdef FD_ROUND_EN
    num = num + (1 << (PHW - 1));
`endif
    return (x + fdiv(num, 1 << PHW)) * apo;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    out_q.delete();
    out_c.delete();
  endtask

  task automatic lut_wr(input int a, input int v);
    logic [ADW-1:0] la;
    logic [PHW-1:0] lv;
    la = a[ADW-1:0];
    lv = v[PHW-1:0];
    bus.i_lut_addr  = la;
    bus.i_lut_wdata = lv;
    bus.i_lut_we    = 1'b1;
    step();
    bus.i_lut_we = 1'b0;
    lut_m[a] = v;
  endtask

  task automatic set_apo(input int apo);
    logic [AW-1:0] v;
    v = apo[AW-1:0];
    bus.i_apo_din = v;
  endtask

  task automatic feed(input int x, input bit tx, output int c);
    logic [IW-1:0] v;
    v = x[IW-1:0];
    bus.i_fine_din       = v;
    bus.i_fine_din_valid = 1'b1;
    bus.i_tx_en          = tx;
    step();
    c = cyc;
    bus.i_fine_din_valid = 1'b0;
    bus.i_tx_en          = 1'b0;
  endtask

  task automatic end_line();
    bus.i_start = 1'b0;
    step();
  endtask

  task automatic rand_sample(output int x);
    x = int'($urandom_range(0, (1 << IW) - 1)) - (1 << (IW - 1));
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.i_tx_en = 1'b0; bus.i_start = 1'b0; bus.i_lut_we = 1'b0;
    bus.i_lut_addr = '0; bus.i_lut_wdata = '0; bus.i_fine_din = '0;
    bus.i_fine_din_valid = 1'b0; bus.i_apo_din = '0;
    repeat (3) step();
    vecs++; if (bus.o_dbf_dout !== '0) begin errs++; $display("FAIL reset_dout: got %0d expected 0", bus.o_dbf_dout); end
    vecs++; if (bus.o_dbf_dout_valid !== 1'b0) begin errs++; $display("FAIL reset_valid: got %b expected 0", bus.o_dbf_dout_valid); end
    vecs++; if (bus.o_lut_done !== 1'b0) begin errs++; $display("FAIL reset_done: got %b expected 0", bus.o_lut_done); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_passthrough();
    int xs[3] = '{5, -7, 100};
    int ic[3];
    for (int i = 0; i < DEPTH; i++) lut_wr(i, 0);
    set_apo(1);
    clear_mon();
    bus.i_start = 1'b1; step();
    for (int i = 0; i < 3; i++) feed(xs[i], 1'b0, ic[i]);
    repeat (5) step();
    vecs++; if (out_q.size() != 3) begin errs++; $display("FAIL pass_count: got %0d expected 3", out_q.size()); end
    for (int i = 0; i < 3 && i < out_q.size(); i++) begin
      vecs++; if (out_q[i] != longint'(xs[i])) begin errs++; $display("FAIL pass_val[%0d]: got %0d expected %0d", i, out_q[i], xs[i]); end
      vecs++; if (out_c[i] - ic[i] != LAT) begin errs++; $display("FAIL pass_lat[%0d]: got %0d expected %0d", i, out_c[i] - ic[i], LAT); end
    end
    end_line();
  endtask

  task automatic test_interp();
    int c;
    lut_wr(1, 2);
    set_apo(2);
    clear_mon();
    bus.i_start = 1'b1; step();
    feed(100, 1'b0, c);
    feed(200, 1'b0, c);
    repeat (5) step();
    vecs++; if (out_q.size() != 2) begin errs++; $display("FAIL interp_count: got %0d expected 2", out_q.size()); end
    if (out_q.size() == 2) begin
      vecs++; if (out_q[0] != 200) begin errs++; $display("FAIL interp_first: got %0d expected 200", out_q[0]); end
      vecs++; if (out_q[1] != 300) begin errs++; $display("FAIL interp_second: got %0d expected 300", out_q[1]); end
    end
    end_line();
  endtask

  task automatic test_floor();
    int c;
    longint exp2;
`ifdef FD_ROUND_EN
    exp2 = 2;
`else
    exp2 = 1;
`endif
    lut_wr(1, 1);
    set_apo(1);
    clear_mon();
    bus.i_start = 1'b1; step();
    feed(0, 1'b0, c);
    feed(2, 1'b0, c);
    repeat (5) step();
    vecs++; if (out_q.size() != 2) begin errs++; $display("FAIL floor_count: got %0d expected 2", out_q.size()); end
    if (out_q.size() == 2) begin
      vecs++; if (out_q[1] != exp2) begin errs++; $display("FAIL floor_val: got %0d expected %0d", out_q[1], exp2); end
    end
    end_line();
  endtask

  task automatic test_tx_blank();
    int c, x;
    longint e0, e1;
    lut_wr(0, 2);
    lut_wr(1, 0);
    set_apo(1);
    clear_mon();
    bus.i_start = 1'b1; step();
    for (int i = 0; i < 4; i++) begin
      rand_sample(x);
      feed(x, 1'b1, c);
    end
    repeat (4) step();
    vecs++; if (out_q.size() != 0) begin errs++; $display("FAIL tx_no_output: got %0d outputs expected 0", out_q.size()); end
    vecs++; if (bus.o_lut_done !== 1'b0) begin errs++; $display("FAIL tx_done: got %b expected 0", bus.o_lut_done); end
    e0 = ref_out(40, 0, lut_m[0], 1);
    e1 = ref_out(80, 40, lut_m[1], 1);
    feed(40, 1'b0, c);
    feed(80, 1'b0, c);
    repeat (5) step();
    vecs++; if (out_q.size() != 2) begin errs++; $display("FAIL tx_resume_count: got %0d expected 2", out_q.size()); end
    if (out_q.size() == 2) begin
      vecs++; if (out_q[0] != e0) begin errs++; $display("FAIL tx_resume0: got %0d expected %0d", out_q[0], e0); end
      vecs++; if (out_q[1] != e1) begin errs++; $display("FAIL tx_resume1: got %0d expected %0d", out_q[1], e1); end
    end
    end_line();
  endtask

  task automatic test_done();
    int c, x, xp, apo;
    longint exp_q[$];
    for (int i = 0; i < DEPTH; i++) lut_wr(i, int'($urandom_range(0, (1 << PHW) - 1)));
    apo = int'($urandom_range(0, 65535)) - 32768;
    set_apo(apo);
    clear_mon();
    bus.i_start = 1'b1; step();
    xp = 0;
    for (int k = 0; k < 6; k++) begin
      rand_sample(x);
      feed(x, 1'b0, c);
      if (k < DEPTH) exp_q.push_back(ref_out(x, xp, lut_m[k], apo));
      xp = x;
      if (k == DEPTH - 2) begin
        vecs++; if (bus.o_lut_done !== 1'b0) begin errs++; $display("FAIL done_early: got %b expected 0", bus.o_lut_done); end
      end
      if (k == DEPTH - 1) begin
        vecs++; if (bus.o_lut_done !== 1'b1) begin errs++; $display("FAIL done_set: got %b expected 1", bus.o_lut_done); end
      end
    end
    repeat (5) step();
    vecs++; if (out_q.size() != DEPTH) begin errs++; $display("FAIL done_count: got %0d expected %0d", out_q.size(), DEPTH); end
    for (int i = 0; i < DEPTH && i < out_q.size(); i++) begin
      vecs++; if (out_q[i] != exp_q[i]) begin errs++; $display("FAIL done_val[%0d]: got %0d expected %0d", i, out_q[i], exp_q[i]); end
    end
    end_line();
    vecs++; if (bus.o_lut_done !== 1'b0) begin errs++; $display("FAIL done_clear: got %b expected 0", bus.o_lut_done); end
  endtask

  task automatic test_abort();
    int c;
    for (int i = 0; i < DEPTH; i++) lut_wr(i, 0);
    set_apo(3);
    clear_mon();
    bus.i_start = 1'b1; step();
    feed(11, 1'b0, c);
    feed(22, 1'b0, c);
    bus.i_start = 1'b0;
    feed(33, 1'b0, c);
    repeat (5) step();
    vecs++; if (out_q.size() != 0) begin errs++; $display("FAIL abort_flush: got %0d outputs expected 0", out_q.size()); end

    bus.i_start = 1'b1; step();
    feed(10, 1'b0, c);
    feed(20, 1'b0, c);
    feed(30, 1'b0, c);
    repeat (4) step();
    vecs++; if (bus.o_dbf_dout !== 32'sd90) begin errs++; $display("FAIL prerst_dout: got %0d expected 90", bus.o_dbf_dout); end
    bus.i_start = 1'b0;
    bus.i_start = 1'b1;
    step();
    feed(-5, 1'b0, c);
    feed(7, 1'b0, c);
    #2 rst = 1'b1;
    #1;
    clear_mon();
    vecs++; if (bus.o_dbf_dout !== '0) begin errs++; $display("FAIL midrst_dout: got %0d expected 0", bus.o_dbf_dout); end
    vecs++; if (bus.o_dbf_dout_valid !== 1'b0) begin errs++; $display("FAIL midrst_valid: got %b expected 0", bus.o_dbf_dout_valid); end
    vecs++; if (bus.o_lut_done !== 1'b0) begin errs++; $display("FAIL midrst_done: got %b expected 0", bus.o_lut_done); end
    bus.i_start = 1'b0;
    step();
    rst = 1'b0;
    repeat (5) step();
    vecs++; if (out_q.size() != 0) begin errs++; $display("FAIL postrst_output: got %0d outputs expected 0", out_q.size()); end
  endtask

  task automatic test_back_to_back();
    int c, x, xp, apo;
    longint exp_q[$];
    int in_q[$];
    for (int line = 0; line < 12; line++) begin
      for (int i = 0; i < DEPTH; i++) lut_wr(i, int'($urandom_range(0, (1 << PHW) - 1)));
      apo = int'($urandom_range(0, 65535)) - 32768;
      set_apo(apo);
      clear_mon();
      exp_q.delete();
      in_q.delete();
      bus.i_start = 1'b1; step();
      xp = 0;
      for (int k = 0; k < DEPTH; k++) begin
        repeat ($urandom_range(0, 2)) begin
          if ($urandom_range(0, 1) == 1) begin
            rand_sample(x);
            feed(x, 1'b1, c);
          end else begin
            step();
          end
        end
        rand_sample(x);
        feed(x, 1'b0, c);
        exp_q.push_back(ref_out(x, xp, lut_m[k], apo));
        in_q.push_back(c);
        xp = x;
      end
      repeat (5) step();
      vecs++; if (bus.o_lut_done !== 1'b1) begin errs++; $display("FAIL rnd_done[%0d]: got %b expected 1", line, bus.o_lut_done); end
      vecs++; if (out_q.size() != DEPTH) begin errs++; $display("FAIL rnd_count[%0d]: got %0d expected %0d", line, out_q.size(), DEPTH); end
      for (int i = 0; i < DEPTH && i < out_q.size(); i++) begin
        vecs++; if (out_q[i] != exp_q[i]) begin errs++; $display("FAIL rnd_val[%0d][%0d]: got %0d expected %0d", line, i, out_q[i], exp_q[i]); end
        vecs++; if (out_c[i] - in_q[i] != LAT) begin errs++; $display("FAIL rnd_lat[%0d][%0d]: got %0d expected %0d", line, i, out_c[i] - in_q[i], LAT); end
      end
      end_line();
    end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_interp();
    test_floor();
    test_tx_blank();
    test_done();
    test_abort();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
